// File: rtl/bet_ledger_if.sv
// Bet ledger bus: bet offers and round control in, slot contents and status out.
// The master side drives the strobes, the slave side is the ledger itself.
interface bet_ledger_if #(
    parameter int MAX_BETS = 12,
    parameter int BET_W    = 8
);
    localparam int CNT_W = $clog2(MAX_BETS + 1);

    logic                      bet_valid;
    logic [BET_W-1:0]          bet_data;
    logic                      spin_req;
    logic                      round_done;
    logic                      bet_undo;
    logic                      bet_accept;
    logic                      bet_reject;
    logic                      bet_ack_led;
    logic                      locked;
    logic                      full;
    logic [CNT_W-1:0]          bet_count;
    logic [MAX_BETS*BET_W-1:0] bets_flat;

    modport master (
        output bet_valid, bet_data, spin_req, round_done, bet_undo,
        input  bet_accept, bet_reject, bet_ack_led, locked, full, bet_count, bets_flat
    );

    modport slave (
        input  bet_valid, bet_data, spin_req, round_done, bet_undo,
        output bet_accept, bet_reject, bet_ack_led, locked, full, bet_count, bets_flat
    );
endinterface

// File: rtl/bet_ledger.sv
// Roulette bet ledger: ordered bet slots, spin lock, post-payout wipe, stretched ack LED.
// Optional macro BET_UNDO_EN enables removal of the newest bet via bet_undo.
module bet_ledger #(
    parameter int MAX_BETS    = 12,
    parameter int BET_W       = 8,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input logic         clock,
    input logic         reset_n,
    bet_ledger_if.slave bus
);
    localparam int CNT_W   = $clog2(MAX_BETS + 1);
    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        OPEN,
        LOCKED,
        CLEAR
    } state_t;

    state_t               state_q, state_d;
    logic [BET_W-1:0]     slots_q [MAX_BETS];
    logic [BET_W-1:0]     slots_d [MAX_BETS];
    logic [CNT_W-1:0]     count_q, count_d;
    logic [TIMER_W-1:0]   ackTimer_q, ackTimer_d;
    logic                 accept_q, accept_d;
    logic                 reject_q, reject_d;
    logic                 led_q;
    logic                 isFull;
    logic [MAX_BETS*BET_W-1:0] flat;

`ifndef BET_UNDO_EN
    logic unusedUndo;
    assign unusedUndo = bus.bet_undo;
`endif

    assign isFull = (count_q == CNT_W'(MAX_BETS));

    // Next-state logic: a bet in the same cycle as a spin is stored before the lock decision.
    always_comb begin
        state_d  = state_q;
        slots_d  = slots_q;
        count_d  = count_q;
        accept_d = 1'b0;
        reject_d = 1'b0;

        case (state_q)
            OPEN: begin
`ifdef BET_UNDO_EN
                if (bus.bet_undo && (count_q != '0)) begin
                    for (int k = 0; k < MAX_BETS; k++) begin
                        if (CNT_W'(k) == count_q - 1'b1) begin
                            slots_d[k] = '0;
                        end
                    end
                    count_d  = count_q - 1'b1;
                    reject_d = bus.bet_valid;
                end else
`endif
                if (bus.bet_valid) begin
                    if (isFull) begin
                        reject_d = 1'b1;
                    end else begin
                        for (int k = 0; k < MAX_BETS; k++) begin
                            if (CNT_W'(k) == count_q) begin
                                slots_d[k] = bus.bet_data;
                            end
                        end
                        count_d  = count_q + 1'b1;
                        accept_d = 1'b1;
                    end
                end
                if (bus.spin_req && (count_d != '0)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                reject_d = bus.bet_valid;
                if (bus.round_done) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                reject_d = bus.bet_valid;
                for (int k = 0; k < MAX_BETS; k++) begin
                    slots_d[k] = '0;
                end
                count_d = '0;
                state_d = OPEN;
            end
            default: begin
                state_d = OPEN;
            end
        endcase
    end

    // Each accept reloads the stretch timer, so the LED measures from the newest bet.
    always_comb begin
        ackTimer_d = ackTimer_q;
        if (accept_d) begin
            ackTimer_d = TIMER_W'(HOLD_CYCLES);
        end else if (ackTimer_q != '0) begin
            ackTimer_d = ackTimer_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OPEN;
            count_q    <= '0;
            ackTimer_q <= '0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            led_q      <= 1'b0;
            for (int k = 0; k < MAX_BETS; k++) begin
                slots_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ackTimer_q <= ackTimer_d;
            accept_q   <= accept_d;
            reject_q   <= reject_d;
            led_q      <= (ackTimer_d != '0);
            for (int k = 0; k < MAX_BETS; k++) begin
                slots_q[k] <= slots_d[k];
            end
        end
    end

    always_comb begin
        flat = '0;
        for (int k = 0; k < MAX_BETS; k++) begin
            flat[k*BET_W +: BET_W] = slots_q[k];
        end
    end

    assign bus.bet_accept  = accept_q;
    assign bus.bet_reject  = reject_q;
    assign bus.bet_ack_led = led_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.full        = isFull;
    assign bus.bet_count   = count_q;
    assign bus.bets_flat   = flat;
endmodule
